// File: rtl/hbconsole_mux.sv
// hbconsole_mux
//
// Shares one UART byte stream between two 7-bit character channels: the
// console peripheral and the hexbus debug bus. Bit 7 of each UART byte
// tags the channel (1 = hexbus, 0 = console).
//
// Receive side: a registered demux. It has no back-pressure.
// Transmit side: a single output register feeds the UART. Once a hexbus
// response starts, it stays contiguous up to its terminating newline (the
// HB_LOCK state). A stalled response is released after an idle timeout.
// When both channels are pending in IDLE, they alternate per packet.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_rx_stb, i_rx_data     UART receive byte strobe/data
//   o_console_stb/_data     console receive character
//   o_hb_stb, o_hb_byte     hexbus receive character
//   i_console_stb/_data     console transmit request/character
//   o_console_busy          console transmit back-pressure
//   i_hb_stb, i_hb_byte     hexbus transmit request/character
//   o_hb_busy               hexbus transmit back-pressure
//   o_tx_stb, o_tx_data     UART transmit request/byte
//   i_tx_busy               UART transmitter busy
//
// Parameter:
//   LGTIMEOUT               log2 of the hexbus-lock idle timeout (2..20)

module hbconsole_mux #(
  parameter int LGTIMEOUT = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_stb,
  input  logic [7:0] i_rx_data,
  output logic       o_console_stb,
  output logic [6:0] o_console_data,
  output logic       o_hb_stb,
  output logic [6:0] o_hb_byte,
  input  logic       i_console_stb,
  input  logic [6:0] i_console_data,
  output logic       o_console_busy,
  input  logic       i_hb_stb,
  input  logic [6:0] i_hb_byte,
  output logic       o_hb_busy,
  output logic       o_tx_stb,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    HB_LOCK = 1'b1
  } state_t;

  localparam logic [6:0] NEWLINE = 7'h0a;

  state_t               state;
  logic                 last_hb;
  logic [LGTIMEOUT-1:0] idle_count;

  logic load_ok;
  logic sel_hb;
  logic sel_con;
  logic hb_accept;
  logic con_accept;
  logic hb_newline;
  logic timed_out;

  // Receive demux
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_console_stb  <= 1'b0;
      o_hb_stb       <= 1'b0;
      o_console_data <= 7'h00;
      o_hb_byte      <= 7'h00;
    end else begin
      o_console_stb <= i_rx_stb && !i_rx_data[7];
      o_hb_stb      <= i_rx_stb && i_rx_data[7];
      if (i_rx_stb) begin
        o_console_data <= i_rx_data[6:0];
        o_hb_byte      <= i_rx_data[6:0];
      end
    end
  end

  // Arbitration. In HB_LOCK only the hexbus can be selected. In IDLE,
  // last_hb breaks a tie so the two channels alternate per packet.
  always_comb begin
    sel_hb  = 1'b0;
    sel_con = 1'b0;
    if (state == HB_LOCK) begin
      sel_hb = i_hb_stb;
    end else if (i_hb_stb && i_console_stb) begin
      if (last_hb)
        sel_con = 1'b1;
      else
        sel_hb = 1'b1;
    end else begin
      sel_hb  = i_hb_stb;
      sel_con = i_console_stb;
    end
  end

  // The output register can take a new byte when it is empty or is
  // being drained by the UART this very cycle.
  assign load_ok        = !o_tx_stb || !i_tx_busy;
  assign o_hb_busy      = !(load_ok && sel_hb);
  assign o_console_busy = !(load_ok && sel_con);

  assign hb_accept  = i_hb_stb && !o_hb_busy;
  assign con_accept = i_console_stb && !o_console_busy;
  assign hb_newline = hb_accept && (i_hb_byte == NEWLINE);
  assign timed_out  = &idle_count;

  // UART output register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_stb  <= 1'b0;
      o_tx_data <= 8'h00;
    end else if (hb_accept) begin
      o_tx_stb  <= 1'b1;
      o_tx_data <= {1'b1, i_hb_byte};
    end else if (con_accept) begin
      o_tx_stb  <= 1'b1;
      o_tx_data <= {1'b0, i_console_data};
    end else if (!i_tx_busy) begin
      o_tx_stb <= 1'b0;
    end
  end

  // Lock FSM and idle timeout. A hexbus accept always takes precedence
  // over the timeout. Both paths leave the FSM in IDLE with last_hb set
  // when the packet ends.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      last_hb    <= 1'b0;
      idle_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_count <= '0;
          if (hb_accept) begin
            if (hb_newline)
              last_hb <= 1'b1;
            else
              state <= HB_LOCK;
          end else if (con_accept) begin
            last_hb <= 1'b0;
          end
        end
        HB_LOCK: begin
          if (hb_accept) begin
            idle_count <= '0;
            if (hb_newline) begin
              state   <= IDLE;
              last_hb <= 1'b1;
            end
          end else if (timed_out) begin
            state      <= IDLE;
            last_hb    <= 1'b1;
            idle_count <= '0;
          end else begin
            idle_count <= idle_count + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          idle_count <= '0;
        end
      endcase
    end
  end

endmodule
